// File: rtl/glitch_sequencer.sv
// glitch_sequencer: executes a short program fetched from an instruction ROM.
// Word format {op[11:10], bus[9], data[8:1], ack[0]}.
//   op 10 DELAY   : wait delay_len(data) cycles
//   op 01 DAC_UP  : hand data to the DAC driver over valid/ready
//   op 00 I2C_CHK : wait for a sniffed byte on bus; runs of CHK words form one
//                   pattern and any mismatch rewinds to the first word of it
//   op 11         : reserved, executes as NOP
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, abort          run request (IDLE only) / sync abort (any state)
//   instr_pt, instr       ROM address out, ROM word in
//   delay_num, delay_len  delay-table index out, cycle count in
//   dac_valid/data/ready  DAC update handshake
//   i2c_sel               bus the current CHK word watches
//   mon_valid/bus/byte/ack sniffed byte strobe from the I2C monitor
//   busy, done            not-idle flag, 1-cycle completion pulse
module glitch_sequencer #(
  parameter int PROG_LEN = 21,
  parameter int PT_W     = 8,
  parameter int DELAY_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [PT_W-1:0]    instr_pt,
  input  logic [11:0]        instr,
  output logic [7:0]         delay_num,
  input  logic [DELAY_W-1:0] delay_len,
  output logic               dac_valid,
  output logic [7:0]         dac_data,
  input  logic               dac_ready,
  output logic               i2c_sel,
  input  logic               mon_valid,
  input  logic               mon_bus,
  input  logic [7:0]         mon_byte,
  input  logic               mon_ack,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DISP, S_DELAY, S_DAC, S_CHK, S_DONE
  } state_t;

  localparam logic [1:0]      OP_CHK   = 2'b00;
  localparam logic [1:0]      OP_DAC   = 2'b01;
  localparam logic [1:0]      OP_DELAY = 2'b10;
  localparam logic [PT_W-1:0] PT_END   = PT_W'(PROG_LEN);
  localparam logic [PT_W-1:0] PT_ONE   = PT_W'(1);

  state_t             state, state_n;
  logic [PT_W-1:0]    pt, pt_n;
  logic [PT_W-1:0]    chk_base, base_n;
  logic [11:0]        ir, ir_n;
  logic [DELAY_W-1:0] cnt, cnt_n;
  logic               prev_chk, prev_n;
  logic               dv_n;
  logic [7:0]         dd_n;
  logic [1:0]         op;

  assign op        = ir[11:10];
  assign instr_pt  = pt;
  assign delay_num = ir[8:1];
  assign i2c_sel   = ir[9];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pt        <= '0;
      chk_base  <= '0;
      ir        <= '0;
      cnt       <= '0;
      prev_chk  <= 1'b0;
      dac_valid <= 1'b0;
      dac_data  <= '0;
    end else begin
      state     <= state_n;
      pt        <= pt_n;
      chk_base  <= base_n;
      ir        <= ir_n;
      cnt       <= cnt_n;
      prev_chk  <= prev_n;
      dac_valid <= dv_n;
      dac_data  <= dd_n;
    end
  end

  always_comb begin
    state_n = state;
    pt_n    = pt;
    base_n  = chk_base;
    ir_n    = ir;
    cnt_n   = cnt;
    prev_n  = prev_chk;
    dv_n    = dac_valid;
    dd_n    = dac_data;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          pt_n    = '0;
          prev_n  = 1'b0;
          state_n = S_FETCH;
        end
      end

      S_FETCH: begin
        if (pt == PT_END) begin
          state_n = S_DONE;
        end else begin
          ir_n    = instr;
          state_n = S_DISP;
        end
      end

      S_DISP: begin
        // chk_base is latched only on the first word of a CHK run
        prev_n = (op == OP_CHK);
        case (op)
          OP_DELAY: begin
            cnt_n = delay_len;
            if (delay_len == '0) begin
              pt_n    = pt + PT_ONE;
              state_n = S_FETCH;
            end else begin
              state_n = S_DELAY;
            end
          end
          OP_DAC: begin
            dv_n    = 1'b1;
            dd_n    = ir[8:1];
            state_n = S_DAC;
          end
          OP_CHK: begin
            if (!prev_chk) base_n = pt;
            state_n = S_CHK;
          end
          default: begin
            pt_n    = pt + PT_ONE;
            state_n = S_FETCH;
          end
        endcase
      end

      S_DELAY: begin
        // loaded with delay_len, leaves on the cycle cnt reads 1:
        // the state therefore lasts exactly delay_len cycles
        cnt_n = cnt - DELAY_W'(1);
        if (cnt == DELAY_W'(1)) begin
          pt_n    = pt + PT_ONE;
          state_n = S_FETCH;
        end
      end

      S_DAC: begin
        if (dac_ready) begin
          dv_n    = 1'b0;
          pt_n    = pt + PT_ONE;
          state_n = S_FETCH;
        end
      end

      S_CHK: begin
        if (mon_valid && (mon_bus == ir[9])) begin
          if ((mon_byte == ir[8:1]) && (mon_ack == ir[0])) begin
            pt_n    = pt + PT_ONE;
            state_n = S_FETCH;
          end else begin
            // restart the whole pattern; the offending byte is dropped
            pt_n    = chk_base;
            prev_n  = 1'b0;
            state_n = S_FETCH;
          end
        end
      end

      S_DONE: begin
        pt_n    = '0;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    if (abort) begin
      state_n = S_IDLE;
      pt_n    = '0;
      dv_n    = 1'b0;
    end
  end

endmodule
